// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM states
// and the mux/ALUOp encodings that the datapath and ALU control decoder agree on.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT       = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  // Dispatch target out of DECODE; unsupported opcodes fall back to FETCH.
  function automatic state_t decodeNext(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_EXEC;
      OP_BEQ:       nxt = S_BRANCH;
      OP_J:         nxt = S_JUMP;
      OP_ADDI:      nxt = S_ADDIEX;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic isSupported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outputs.sv
// Moore output decode for the multicycle control FSM. Only FETCH looks at
// memReady (to gate IRWrite/PCWrite) and DECODE at the opcode (IllegalOp).
module multicycle_ctrl_outputs
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    IllegalOp   = 1'b0;
    case (state)
      // PC+4 is written only on the cycle the fetch completes.
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALUOP_ADD;
        IRWrite = memReady;
        PCWrite = memReady;
      end
      S_DECODE: begin
        ALUSrcB   = SRCB_IMM_SHL2;
        ALUOp     = ALUOP_ADD;
        IllegalOp = !isSupported(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        RegDst   = 1'b0;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RT;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control unit: state register, next-state logic and the
// retired-instruction counter; output decode lives in multicycle_ctrl_outputs.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       State
);

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] instrCount;
  logic             memReadyEff;

  // Without the handshake every memory access completes in a single cycle.
  assign memReadyEff = MemReady || (MEM_HANDSHAKE == 0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      instrCount <= '0;
    end else begin
      state <= nextState;
      if (state == S_FETCH && memReadyEff) begin
        instrCount <= instrCount + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nextState = S_FETCH;
    case (state)
      S_IDLE:   nextState = S_FETCH;
      S_FETCH:  nextState = memReadyEff ? S_DECODE : S_FETCH;
      S_DECODE: nextState = decodeNext(Opcode);
      S_MEMADR: nextState = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nextState = memReadyEff ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nextState = S_FETCH;
      S_MEMWR:  nextState = memReadyEff ? S_FETCH : S_MEMWR;
      S_EXEC:   nextState = S_RWB;
      S_RWB:    nextState = S_FETCH;
      S_BRANCH: nextState = S_FETCH;
      S_JUMP:   nextState = S_FETCH;
      S_ADDIEX: nextState = S_ADDIWB;
      S_ADDIWB: nextState = S_FETCH;
      default:  nextState = S_FETCH;
    endcase
  end

  multicycle_ctrl_outputs u_outputs (
    .state       (state),
    .opcode      (Opcode),
    .memReady    (memReadyEff),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .IllegalOp   (IllegalOp)
  );

  assign State      = state;
  assign InstrCount = instrCount;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// the FSM and compares state, packed control outputs and the fetch counter.
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  Opcode;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] InstrCount;
  logic [3:0]  State;
  logic [16:0] ctrlBus;

  int assertsDone = 0;
  int failCount   = 0;

  // Bus order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
  // RegWrite ALUSrcA | ALUSrcB | ALUOp | PCSource | IllegalOp
  localparam logic [16:0] E_IDLE   = 17'd0;
  localparam logic [16:0] E_FETCH  = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_FETCHW = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_DECODE = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_DECILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [16:0] E_MEMADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MEMWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_EXEC   = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] E_RWB    = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_BRANCH = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [16:0] E_JUMP   = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] E_ADDIEX = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_ADDIWB = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [5:0]  OP_BAD   = 6'b111111;

  typedef struct packed {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] bus;
    logic [31:0] cnt;
  } cyc_t;

  assign ctrlBus = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

  always #5 clk = ~clk;

  multicycle_control #(.MEM_HANDSHAKE(1), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Opcode      (Opcode),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .IllegalOp   (IllegalOp),
    .InstrCount  (InstrCount),
    .State       (State)
  );

  task automatic test_reset();
    rst_n = 1'b0; MemReady = 1'b0; Opcode = OP_RTYPE;
    repeat (2) @(posedge clk);
    #1;
    assertsDone++;
    if (State !== 4'd0) begin failCount++; $display("[TB] FAIL reset_state: got %0d want 0", State); end
    assertsDone++;
    if (ctrlBus !== E_IDLE) begin failCount++; $display("[TB] FAIL reset_outputs: got %h want %h", ctrlBus, E_IDLE); end
    assertsDone++;
    if (InstrCount !== 32'd0) begin failCount++; $display("[TB] FAIL reset_count: got %0d want 0", InstrCount); end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    cyc_t v [5];
    v = '{'{OP_RTYPE, 1'b1, S_IDLE,   E_IDLE,   32'd0},
          '{OP_RTYPE, 1'b1, S_FETCH,  E_FETCH,  32'd0},
          '{OP_RTYPE, 1'b1, S_DECODE, E_DECODE, 32'd1},
          '{OP_RTYPE, 1'b1, S_EXEC,   E_EXEC,   32'd1},
          '{OP_RTYPE, 1'b1, S_RWB,    E_RWB,    32'd1}};
    for (int i = 0; i < 5; i++) begin
      Opcode = v[i].op; MemReady = v[i].mr; #1;
      assertsDone++;
      if (State !== v[i].st) begin failCount++; $display("[TB] FAIL rtype_state c%0d: got %0d want %0d", i, State, v[i].st); end
      assertsDone++;
      if (ctrlBus !== v[i].bus) begin failCount++; $display("[TB] FAIL rtype_outputs c%0d: got %h want %h", i, ctrlBus, v[i].bus); end
      assertsDone++;
      if (InstrCount !== v[i].cnt) begin failCount++; $display("[TB] FAIL rtype_count c%0d: got %0d want %0d", i, InstrCount, v[i].cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    cyc_t v [8];
    v = '{'{OP_LW, 1'b1, S_FETCH,  E_FETCH,  32'd1},
          '{OP_LW, 1'b1, S_DECODE, E_DECODE, 32'd2},
          '{OP_LW, 1'b1, S_MEMADR, E_MEMADR, 32'd2},
          '{OP_LW, 1'b0, S_MEMRD,  E_MEMRD,  32'd2},
          '{OP_LW, 1'b0, S_MEMRD,  E_MEMRD,  32'd2},
          '{OP_LW, 1'b0, S_MEMRD,  E_MEMRD,  32'd2},
          '{OP_LW, 1'b1, S_MEMRD,  E_MEMRD,  32'd2},
          '{OP_LW, 1'b1, S_MEMWB,  E_MEMWB,  32'd2}};
    for (int i = 0; i < 8; i++) begin
      Opcode = v[i].op; MemReady = v[i].mr; #1;
      assertsDone++;
      if (State !== v[i].st) begin failCount++; $display("[TB] FAIL lw_state c%0d: got %0d want %0d", i, State, v[i].st); end
      assertsDone++;
      if (ctrlBus !== v[i].bus) begin failCount++; $display("[TB] FAIL lw_outputs c%0d: got %h want %h", i, ctrlBus, v[i].bus); end
      assertsDone++;
      if (InstrCount !== v[i].cnt) begin failCount++; $display("[TB] FAIL lw_count c%0d: got %0d want %0d", i, InstrCount, v[i].cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_fetch_wait();
    cyc_t v [8];
    v = '{'{OP_SW, 1'b0, S_FETCH,  E_FETCHW, 32'd2},
          '{OP_SW, 1'b0, S_FETCH,  E_FETCHW, 32'd2},
          '{OP_SW, 1'b1, S_FETCH,  E_FETCH,  32'd2},
          '{OP_SW, 1'b1, S_DECODE, E_DECODE, 32'd3},
          '{OP_SW, 1'b1, S_MEMADR, E_MEMADR, 32'd3},
          '{OP_SW, 1'b0, S_MEMWR,  E_MEMWR,  32'd3},
          '{OP_SW, 1'b0, S_MEMWR,  E_MEMWR,  32'd3},
          '{OP_SW, 1'b1, S_MEMWR,  E_MEMWR,  32'd3}};
    for (int i = 0; i < 8; i++) begin
      Opcode = v[i].op; MemReady = v[i].mr; #1;
      assertsDone++;
      if (State !== v[i].st) begin failCount++; $display("[TB] FAIL sw_state c%0d: got %0d want %0d", i, State, v[i].st); end
      assertsDone++;
      if (ctrlBus !== v[i].bus) begin failCount++; $display("[TB] FAIL sw_outputs c%0d: got %h want %h", i, ctrlBus, v[i].bus); end
      assertsDone++;
      if (InstrCount !== v[i].cnt) begin failCount++; $display("[TB] FAIL sw_count c%0d: got %0d want %0d", i, InstrCount, v[i].cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    cyc_t v [6];
    v = '{'{OP_BEQ, 1'b1, S_FETCH,  E_FETCH,  32'd3},
          '{OP_BEQ, 1'b1, S_DECODE, E_DECODE, 32'd4},
          '{OP_BEQ, 1'b1, S_BRANCH, E_BRANCH, 32'd4},
          '{OP_J,   1'b1, S_FETCH,  E_FETCH,  32'd4},
          '{OP_J,   1'b1, S_DECODE, E_DECODE, 32'd5},
          '{OP_J,   1'b1, S_JUMP,   E_JUMP,   32'd5}};
    for (int i = 0; i < 6; i++) begin
      Opcode = v[i].op; MemReady = v[i].mr; #1;
      assertsDone++;
      if (State !== v[i].st) begin failCount++; $display("[TB] FAIL brj_state c%0d: got %0d want %0d", i, State, v[i].st); end
      assertsDone++;
      if (ctrlBus !== v[i].bus) begin failCount++; $display("[TB] FAIL brj_outputs c%0d: got %h want %h", i, ctrlBus, v[i].bus); end
      assertsDone++;
      if (InstrCount !== v[i].cnt) begin failCount++; $display("[TB] FAIL brj_count c%0d: got %0d want %0d", i, InstrCount, v[i].cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
    cyc_t v [4];
    v = '{'{OP_ADDI, 1'b1, S_FETCH,  E_FETCH,  32'd5},
          '{OP_ADDI, 1'b1, S_DECODE, E_DECODE, 32'd6},
          '{OP_ADDI, 1'b1, S_ADDIEX, E_ADDIEX, 32'd6},
          '{OP_ADDI, 1'b1, S_ADDIWB, E_ADDIWB, 32'd6}};
    for (int i = 0; i < 4; i++) begin
      Opcode = v[i].op; MemReady = v[i].mr; #1;
      assertsDone++;
      if (State !== v[i].st) begin failCount++; $display("[TB] FAIL addi_state c%0d: got %0d want %0d", i, State, v[i].st); end
      assertsDone++;
      if (ctrlBus !== v[i].bus) begin failCount++; $display("[TB] FAIL addi_outputs c%0d: got %h want %h", i, ctrlBus, v[i].bus); end
      assertsDone++;
      if (InstrCount !== v[i].cnt) begin failCount++; $display("[TB] FAIL addi_count c%0d: got %0d want %0d", i, InstrCount, v[i].cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    cyc_t v [3];
    v = '{'{OP_BAD, 1'b1, S_FETCH,  E_FETCH,  32'd6},
          '{OP_BAD, 1'b1, S_DECODE, E_DECILL, 32'd7},
          '{OP_BAD, 1'b0, S_FETCH,  E_FETCHW, 32'd7}};
    for (int i = 0; i < 3; i++) begin
      Opcode = v[i].op; MemReady = v[i].mr; #1;
      assertsDone++;
      if (State !== v[i].st) begin failCount++; $display("[TB] FAIL illegal_state c%0d: got %0d want %0d", i, State, v[i].st); end
      assertsDone++;
      if (ctrlBus !== v[i].bus) begin failCount++; $display("[TB] FAIL illegal_outputs c%0d: got %h want %h", i, ctrlBus, v[i].bus); end
      assertsDone++;
      if (InstrCount !== v[i].cnt) begin failCount++; $display("[TB] FAIL illegal_count c%0d: got %0d want %0d", i, InstrCount, v[i].cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midaccess();
    cyc_t v [3];
    v = '{'{OP_SW, 1'b1, S_FETCH,  E_FETCH,  32'd7},
          '{OP_SW, 1'b1, S_DECODE, E_DECODE, 32'd8},
          '{OP_SW, 1'b1, S_MEMADR, E_MEMADR, 32'd8}};
    for (int i = 0; i < 3; i++) begin
      Opcode = v[i].op; MemReady = v[i].mr; #1;
      assertsDone++;
      if (State !== v[i].st) begin failCount++; $display("[TB] FAIL midrst_state c%0d: got %0d want %0d", i, State, v[i].st); end
      assertsDone++;
      if (ctrlBus !== v[i].bus) begin failCount++; $display("[TB] FAIL midrst_outputs c%0d: got %h want %h", i, ctrlBus, v[i].bus); end
      @(posedge clk); #1;
    end
    MemReady = 1'b0; #1;
    assertsDone++;
    if (ctrlBus !== E_MEMWR) begin failCount++; $display("[TB] FAIL midrst_memwr: got %h want %h", ctrlBus, E_MEMWR); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    assertsDone++;
    if (State !== 4'd0) begin failCount++; $display("[TB] FAIL midrst_idle: got %0d want 0", State); end
    assertsDone++;
    if (MemWrite !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_memwrite: got %b want 0", MemWrite); end
    assertsDone++;
    if (InstrCount !== 32'd0) begin failCount++; $display("[TB] FAIL midrst_count: got %0d want 0", InstrCount); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    assertsDone++;
    if (State !== 4'd1) begin failCount++; $display("[TB] FAIL midrst_refetch: got %0d want 1", State); end
    assertsDone++;
    if (ctrlBus !== E_FETCHW) begin failCount++; $display("[TB] FAIL midrst_refetch_outputs: got %h want %h", ctrlBus, E_FETCHW); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_fetch_wait();
    test_branch_jump();
    test_addi();
    test_illegal();
    test_reset_midaccess();
    $display("End of test - %0d assertions evaluated, %0d failures", assertsDone, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not end, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle MIPS main control unit, implemented as a Moore FSM.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives datapath enables, muxes and memory strobes.
- Produces the 2-bit ALUOp code consumed by the ALU control decoder (00 = add, 01 = subtract, 10 = use funct field). It is the producer side of that interface.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for MemReady; 0 = MemReady is treated as constant 1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- Opcode  in  6  instruction bits [31:26] from the instruction register. Stable from the DECODE state onward.
- MemReady  in  1  memory has completed the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register-file write data select: 1 = MDR.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  out  1  register-file write enable.
- ALUSrcA  out  1  ALU A input select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B input select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp  out  2  code sent to the ALU control decoder.
- PCSource  out  2  PC next-value select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
- InstrCount  out  CNT_W  number of instructions fetched.
- State  out  4  current state, for debug.

Behaviour:
- Outputs are a combinational function of the state register. Exception: in FETCH, IRWrite and PCWrite are additionally ANDed with MemReady.
- Any output not listed for a state is 0.
- Reset:
  - rst_n = 0 at a clock edge → next state IDLE and InstrCount = 0.
  - This applies from any state, including mid-access; MemWrite/MemRead drop on that edge.
  - In IDLE all outputs are 0 and State = 0.
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, EXEC = 7, RWB = 8, BRANCH = 9, JUMP = 10, ADDIEX = 11, ADDIWB = 12. Codes 13–15 are unreachable; if entered, next state is FETCH.
- IDLE: next state FETCH (unconditional).
- FETCH:
  - MemRead = 1, ALUSrcB = 01, ALUOp = 00, IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady = 0, so the PC increments exactly once per fetch.
  - Goes to DECODE on MemReady = 1.
  - InstrCount increments by 1 on that edge and wraps modulo 2^CNT_W.
- DECODE: ALUSrcB = 11, ALUOp = 00 (branch target computed into ALUOut). Next state by Opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 (addi) → ADDIEX.
  - Any other opcode → FETCH, with IllegalOp = 1 during this DECODE cycle.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead = 1, IorD = 1. Holds until MemReady = 1, then → MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Next → FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Holds until MemReady = 1, then → FETCH. MemWrite stays high for the entire wait.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next → RWB.
- RWB: RegWrite = 1, RegDst = 1. Next → FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Next → FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Next → FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next → ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0. Next → FETCH.
- Cycles per instruction with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- MemRead and MemWrite are never high in the same cycle.
- RegWrite is never high in a memory-wait state.

Decomposition:
- Shared package ctrl_pkg contains:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - the state enum (4-bit);
  - ALUOp constants ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10, shared with the ALU control decoder;
  - ALUSrcB and PCSource encodings.
- One natural sub-module, multicycle_ctrl_outputs: purely combinational state → output decode. The top level holds the state register, next-state logic and InstrCount.

Test Plan:
- Reset then release, MemReady = 1, Opcode = 000000 → State sequence 0, 1, 2, 7, 8, 1. ALUOp = 10 only in EXEC. RegWrite = RegDst = 1 in RWB. InstrCount = 1.
- lw (100011) with MemReady held low 3 cycles in MEMRD → MEMRD lasts 4 cycles with MemRead = IorD = 1, then MEMWB with MemtoReg = RegWrite = 1. Total 8 cycles from FETCH back to FETCH.
- sw (101011), MemReady low for 2 cycles in FETCH → IRWrite/PCWrite are 0 for 2 cycles and then pulse once. MEMWR asserts MemWrite until MemReady. RegWrite is never asserted.
- beq (000100) → BRANCH shows ALUOp = 01, PCWriteCond = 1, PCSource = 01, PCWrite = 0. j (000010) → JUMP shows PCWrite = 1, PCSource = 10.
- Opcode = 111111 → IllegalOp = 1 for exactly the DECODE cycle, next state FETCH, no RegWrite or MemWrite asserted.
- rst_n driven to 0 while in MEMWR with MemReady = 0 → next edge State = 0, MemWrite = 0, InstrCount = 0. After release, FETCH follows one cycle later.
